// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Access width/sign decode is kept here so controller and load extender agree.
package dmem_access_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [7:0]        mask_t;

   typedef enum logic [2:0] {
      MEM_NO = 3'd0,
      MEM_B  = 3'd1,
      MEM_H  = 3'd2,
      MEM_W  = 3'd3,
      MEM_D  = 3'd4,
      MEM_UB = 3'd5,
      MEM_UH = 3'd6,
      MEM_UW = 3'd7
   } mem_op_enum;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      ERR  = 2'd3
   } dmem_state_enum;

   function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] lo);
      logic mis;
      case (op)
         MEM_H, MEM_UH: mis = lo[0];
         MEM_W, MEM_UW: mis = |lo[1:0];
         MEM_D:         mis = |lo;
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Byte enables for an access at lane 0; the caller shifts to the real lane.
   function automatic mask_t base_mask(input mem_op_enum op);
      mask_t m;
      case (op)
         MEM_B, MEM_UB: m = 8'h01;
         MEM_H, MEM_UH: m = 8'h03;
         MEM_W, MEM_UW: m = 8'h0F;
         MEM_D:         m = 8'hFF;
         default:       m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_ext.sv
// Load-data alignment: shifts the addressed lane down to bit 0 and
// sign/zero-extends according to the access type.
module dmem_load_ext
   import dmem_access_ctrl_pkg::*;
(
   input  mem_op_enum  mem_op,
   input  logic [2:0]  addr_lo,
   input  data_t       rdata,
   output data_t       data
);

   data_t shifted;

   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      data = '0;
      case (mem_op)
         MEM_B:  data = {{56{shifted[7]}},  shifted[7:0]};
         MEM_UB: data = {56'd0,             shifted[7:0]};
         MEM_H:  data = {{48{shifted[15]}}, shifted[15:0]};
         MEM_UH: data = {48'd0,             shifted[15:0]};
         MEM_W:  data = {{32{shifted[31]}}, shifted[31:0]};
         MEM_UW: data = {32'd0,             shifted[31:0]};
         MEM_D:  data = shifted;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one pipeline load/store at a time,
// issues it to memory and returns a single-cycle completion.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request (also the completion cycle of MEM_NO/loads/stores)
// REQ   | dmem_req_valid high with latched request, waiting for dmem_req_ready
// WAIT  | request handed off, waiting for dmem_resp_valid
// ERR   | one-cycle misaligned completion, no memory access
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,

   input  logic        req_valid,
   output logic        req_ready,
   input  mem_op_enum  mem_op,
   input  logic        req_we,
   input  addr_t       req_addr,
   input  data_t       req_wdata,

   output logic        resp_valid,
   output data_t       resp_rdata,
   output logic        resp_misalign,

   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output addr_t       dmem_addr,
   output logic        dmem_wen,
   output data_t       dmem_wdata,
   output mask_t       dmem_wmask,

   input  logic        dmem_resp_valid,
   input  data_t       dmem_rdata
);

   dmem_state_enum state;
   mem_op_enum     lat_op;
   logic           lat_we;
   addr_t          lat_addr;
   data_t          lat_wdata;
   data_t          load_data;

   assign dmem_addr  = lat_addr;
   assign dmem_wen   = lat_we;
   assign dmem_wdata = lat_wdata;

   dmem_load_ext u_load_ext (
      .mem_op  (lat_op),
      .addr_lo (lat_addr[2:0]),
      .rdata   (dmem_rdata),
      .data    (load_data)
   );

   // req_ready drops for the completion cycle so the next request lands one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_misalign  <= 1'b0;
         resp_rdata     <= '0;
         dmem_req_valid <= 1'b0;
         dmem_wmask     <= '0;
         lat_op         <= MEM_NO;
         lat_we         <= 1'b0;
         lat_addr       <= '0;
         lat_wdata      <= '0;
      end else begin
         resp_valid    <= 1'b0;
         resp_misalign <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_ready && req_valid) begin
                  req_ready  <= 1'b0;
                  resp_rdata <= '0;
                  if (mem_op == MEM_NO) begin
                     resp_valid <= 1'b1;
                  end else begin
                     lat_op    <= mem_op;
                     lat_we    <= req_we;
                     lat_addr  <= req_addr;
                     lat_wdata <= req_wdata;
                     if (is_misaligned(mem_op, req_addr[2:0])) begin
                        state         <= ERR;
                        resp_valid    <= 1'b1;
                        resp_misalign <= 1'b1;
                        dmem_wmask    <= '0;
                     end else begin
                        state          <= REQ;
                        dmem_req_valid <= 1'b1;
                        dmem_wmask     <= req_we ? (base_mask(mem_op) << req_addr[2:0]) : '0;
                     end
                  end
               end
            end
            REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (dmem_resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= lat_we ? '0 : load_data;
                  state      <= IDLE;
               end
            end
            ERR: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed corner cases, then randomized traffic
// against a byte-array memory model with a response scoreboard.
module tb_dmem_access_ctrl;
   import dmem_access_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   mem_op_enum mem_op;
   logic       req_we;
   addr_t      req_addr;
   data_t      req_wdata;
   logic       resp_valid;
   data_t      resp_rdata;
   logic       resp_misalign;
   logic       dmem_req_valid;
   logic       dmem_req_ready;
   addr_t      dmem_addr;
   logic       dmem_wen;
   data_t      dmem_wdata;
   mask_t      dmem_wmask;
   logic       dmem_resp_valid;
   data_t      dmem_rdata;

   dmem_access_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .mem_op          (mem_op),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misalign   (resp_misalign),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_addr       (dmem_addr),
      .dmem_wen        (dmem_wen),
      .dmem_wdata      (dmem_wdata),
      .dmem_wmask      (dmem_wmask),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_rdata      (dmem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic mis; data_t rdata; } exp_t;
   typedef struct { addr_t addr; logic wen; data_t wdata; mask_t mask; } mexp_t;

   exp_t  sb_q[$];
   mexp_t mq[$];
   int    checks = 0;
   int    errors = 0;
   logic  mem_stop = 1'b0;

   logic [7:0] ref_bytes [64];
   data_t      mem_word  [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int op_size(input mem_op_enum op);
      case (op)
         MEM_B, MEM_UB: return 1;
         MEM_H, MEM_UH: return 2;
         MEM_W, MEM_UW: return 4;
         MEM_D:         return 8;
         default:       return 0;
      endcase
   endfunction

   function automatic logic op_signed(input mem_op_enum op);
      return (op == MEM_B) || (op == MEM_H) || (op == MEM_W);
   endfunction

   // Scoreboard monitor: every completion pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=1 required=0");
         end else begin
            e = sb_q.pop_front();
            chk("resp_misalign", resp_misalign, e.mis);
            chk("resp_rdata", resp_rdata, e.rdata);
         end
      end else if (resp_misalign === 1'b1) begin
         chk("misalign_outside_resp", resp_misalign, 1'b0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic issue(input mem_op_enum op, input logic we, input addr_t a, input data_t wd,
                        input logic emis, input data_t erd, output int waited);
      waited = 0;
      while (req_ready !== 1'b1) begin
         @(negedge clk);
         waited++;
         if (waited > 50) begin
            chk("issue_timeout", waited, 0);
            return;
         end
      end
      req_valid = 1'b1; mem_op = op; req_we = we; req_addr = a; req_wdata = wd;
      sb_q.push_back('{mis: emis, rdata: erd});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic complete(input int stall, input data_t beat, input addr_t ea, input logic ewen,
                           input data_t ewd, input mask_t emask);
      chk("dreq_valid", dmem_req_valid, 1'b1);
      chk("dreq_addr", dmem_addr, ea);
      chk("dreq_wen", dmem_wen, ewen);
      chk("dreq_wmask", dmem_wmask, emask);
      if (ewen) chk("dreq_wdata", dmem_wdata, ewd);
      chk("busy_ready", req_ready, 1'b0);
      dmem_resp_valid = 1'b1;
      dmem_rdata = ~beat;
      for (int i = 0; i < stall; i++) begin
         dmem_req_ready = 1'b0;
         @(negedge clk);
         dmem_resp_valid = 1'b0;
         chk("stall_valid", dmem_req_valid, 1'b1);
         chk("stall_addr", dmem_addr, ea);
         chk("stall_wmask", dmem_wmask, emask);
         chk("stall_wdata", dmem_wdata, ewd);
         chk("stall_ready", req_ready, 1'b0);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready  = 1'b0;
      chk("dreq_drop", dmem_req_valid, 1'b0);
      dmem_resp_valid = 1'b1;
      dmem_rdata      = beat;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      chk("resp_latency", resp_valid, 1'b1);
      chk("resp_cycle_ready", req_ready, 1'b0);
   endtask

   task automatic mem_loop();
      logic  inflight = 1'b0;
      int    delay = 0;
      data_t beat = '0;
      mexp_t m;
      int    idx;
      while (!mem_stop) begin
         @(negedge clk);
         dmem_resp_valid = 1'b0;
         dmem_rdata = {$urandom, $urandom};
         if (inflight) begin
            if (delay == 0) begin
               dmem_resp_valid = 1'b1;
               dmem_rdata      = beat;
               inflight        = 1'b0;
            end else begin
               delay--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            dmem_resp_valid = 1'b1;
         end
         dmem_req_ready = ($urandom_range(0, 3) != 0);
         if (dmem_req_valid === 1'b1 && dmem_req_ready) begin
            if (mq.size() == 0) begin
               chk("unexpected_mem_req", 1'b1, 1'b0);
            end else begin
               m = mq.pop_front();
               chk("mem_addr", dmem_addr, m.addr);
               chk("mem_wen", dmem_wen, m.wen);
               chk("mem_wmask", dmem_wmask, m.mask);
               if (m.wen) chk("mem_wdata", dmem_wdata, m.wdata);
            end
            idx = int'(dmem_addr[5:3]);
            for (int b = 0; b < 8; b++)
               if (dmem_wen && dmem_wmask[b]) mem_word[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
            beat     = mem_word[idx];
            inflight = 1'b1;
            delay    = $urandom_range(0, 2);
         end
      end
   endtask

   task automatic run_random(input int n);
      mem_op_enum op;
      logic       we;
      data_t      wd, val;
      int         sz, off, lane, waited;
      mask_t      mask;
      for (int t = 0; t < n; t++) begin
         op  = mem_op_enum'($urandom_range(0, 7));
         we  = 1'($urandom_range(0, 1));
         wd  = {$urandom, $urandom};
         sz  = op_size(op);
         off = $urandom_range(0, 63);
         if (sz > 1 && $urandom_range(0, 3) != 0) off = off - (off % sz);
         waited = 0;
         @(negedge clk);
         while (req_ready !== 1'b1) begin
            req_valid = 1'($urandom_range(0, 1));
            mem_op    = mem_op_enum'($urandom_range(1, 7));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = {$urandom, $urandom};
            waited++;
            if (waited > 100) begin
               chk("random_issue_timeout", waited, 0);
               return;
            end
            @(negedge clk);
         end
         req_valid = 1'b1; mem_op = op; req_we = we; req_addr = 32'h2000 + off; req_wdata = wd;
         if (sz == 0) begin
            sb_q.push_back('{mis: 1'b0, rdata: '0});
         end else if (off % sz != 0) begin
            sb_q.push_back('{mis: 1'b1, rdata: '0});
         end else begin
            lane = off % 8;
            mask = '0;
            val  = '0;
            for (int k = 0; k < sz; k++) begin
               mask[lane + k] = 1'b1;
               if (we) ref_bytes[off + k] = wd[8*(lane + k) +: 8];
               else    val[8*k +: 8]      = ref_bytes[off + k];
            end
            if (!we && op_signed(op) && val[8*sz - 1])
               for (int b = 8*sz; b < 64; b++) val[b] = 1'b1;
            mq.push_back('{addr: 32'h2000 + off, wen: we, wdata: wd, mask: we ? mask : 8'h00});
            sb_q.push_back('{mis: 1'b0, rdata: we ? '0 : val});
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      int    w;
      data_t beat_a, beat_b;
      rst = 1'b1; req_valid = 1'b0; mem_op = MEM_NO; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_misalign", resp_misalign, 1'b0);
      chk("rst_dreq_valid", dmem_req_valid, 1'b0);
      chk("rst_wmask", dmem_wmask, 8'h00);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // SB at lane 3
      issue(MEM_B, 1'b1, 32'h1003, 64'h0000_0000_AB00_0000, 1'b0, '0, w);
      complete(0, 64'h1111_2222_3333_4444, 32'h1003, 1'b1, 64'h0000_0000_AB00_0000, 8'h08);

      // LH / LHU from the top lane of the same beat
      issue(MEM_H, 1'b0, 32'h2006, '0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, w);
      complete(0, 64'h8001_1234_5678_9ABC, 32'h2006, 1'b0, '0, 8'h00);
      issue(MEM_UH, 1'b0, 32'h2006, '0, 1'b0, 64'h0000_0000_0000_8001, w);
      complete(0, 64'h8001_1234_5678_9ABC, 32'h2006, 1'b0, '0, 8'h00);

      // misaligned LW
      issue(MEM_W, 1'b0, 32'h2002, '0, 1'b1, '0, w);
      chk("err_resp_valid", resp_valid, 1'b1);
      chk("err_misalign", resp_misalign, 1'b1);
      chk("err_no_dreq", dmem_req_valid, 1'b0);
      @(negedge clk);
      chk("err_one_cycle", resp_valid, 1'b0);
      chk("err_back_ready", req_ready, 1'b1);
      chk("err_no_dreq2", dmem_req_valid, 1'b0);

      // SD with 5 stall cycles
      issue(MEM_D, 1'b1, 32'h2008, 64'h0123_4567_89AB_CDEF, 1'b0, '0, w);
      complete(5, 64'h5555_AAAA_5555_AAAA, 32'h2008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF);

      // reset while WAIT, then a stray memory response
      issue(MEM_D, 1'b0, 32'h2010, '0, 1'b0, '0, w);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      chk("rst_wait_no_resp", resp_valid, 1'b0);
      chk("rst_wait_ready", req_ready, 1'b1);
      chk("rst_wait_dreq", dmem_req_valid, 1'b0);
      @(negedge clk);
      chk("rst_wait_no_resp2", resp_valid, 1'b0);

      // back-to-back LD
      beat_a = {$urandom, $urandom};
      beat_b = {$urandom, $urandom};
      issue(MEM_D, 1'b0, 32'h2018, '0, 1'b0, beat_a, w);
      complete(0, beat_a, 32'h2018, 1'b0, '0, 8'h00);
      issue(MEM_D, 1'b0, 32'h2020, '0, 1'b0, beat_b, w);
      chk("b2b_accept_wait", w, 1);
      complete(0, beat_b, 32'h2020, 1'b0, '0, 8'h00);

      // randomized phase
      for (int i = 0; i < 64; i++) begin
         ref_bytes[i] = 8'(i * 37 + 5);
         mem_word[i / 8][8*(i % 8) +: 8] = 8'(i * 37 + 5);
      end
      fork
         begin
            run_random(300);
            w = 0;
            while ((sb_q.size() != 0 || mq.size() != 0) && w < 200) begin
               @(negedge clk);
               w++;
            end
            chk("drain_sb", sb_q.size(), 0);
            chk("drain_mem", mq.size(), 0);
            mem_stop = 1'b1;
         end
         mem_loop();
      join
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The pipeline-side request ports SHALL be:
- req_valid  input  1  access request
- req_ready  output  1  block idle, request accepted this cycle
- mem_op  input  CorePack::mem_op_enum  access width/sign
- req_we  input  1  1=store, 0=load
- req_addr  input  CorePack::addr_t  byte address
- req_wdata  input  CorePack::data_t  lane-shifted store data from the store-packing stage
REQ-003 The pipeline-side response ports SHALL be:
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  CorePack::data_t  extended load data
- resp_misalign  output  1  access misaligned, no memory access issued
REQ-004 The memory-side request ports SHALL be:
- dmem_req_valid  output  1  memory request
- dmem_req_ready  input  1  memory accepts request
- dmem_addr  output  addr_t  request address
- dmem_wen  output  1  write enable
- dmem_wdata  output  data_t  store data
- dmem_wmask  output  8  byte enables
REQ-005 The memory-side response ports SHALL be:
- dmem_resp_valid  input  1  memory response
- dmem_rdata  input  data_t  64-bit read beat

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, ERR; req_ready=1 only in IDLE.
REQ-007 IDLE transitions:
- req_valid and mem_op!=MEM_NO and misaligned: latch the request, go to ERR.
- req_valid and mem_op!=MEM_NO and aligned: latch the request, go to REQ.
- MEM_NO: accepted; completes with a resp_valid pulse the next cycle, no memory traffic.
REQ-008 Misaligned SHALL mean: H/UH with addr[0]!=0; W/UW with addr[1:0]!=0; D with addr[2:0]!=0; B/UB never misaligned.
REQ-009 REQ state:
- dmem_req_valid=1 with latched addr/wen/wdata/wmask held stable until handshake.
- dmem_req_valid & dmem_req_ready moves to WAIT.
REQ-010 WAIT state: on dmem_resp_valid, resp_valid=1 for exactly one cycle with resp_rdata from that beat; return to IDLE.
REQ-011 ERR state SHALL last one cycle with resp_valid=1, resp_misalign=1, resp_rdata=0, then return to IDLE.
REQ-012 dmem_wmask SHALL be (B/UB 8'h01, H/UH 8'h03, W/UW 8'h0F, D 8'hFF) << addr[2:0] for stores, and 8'h00 for loads.
REQ-013 Load data SHALL be computed as follows:
- Shift: dmem_rdata >> {addr[2:0],3'b0}.
- Sign-extend from bit 7/15/31 for B/H/W; zero-extend for UB/UH/UW; D passes all 64 bits.
- Stores return resp_rdata=0.
REQ-014 Minimum latency SHALL be 3 cycles accept-to-resp_valid with dmem_req_ready=1 at REQ and a response the following cycle; back-to-back requests SHALL be accepted the cycle after resp_valid.
REQ-015 dmem_resp_valid outside WAIT SHALL be ignored; req_valid outside IDLE SHALL be ignored (not latched).
REQ-016 resp_valid and resp_misalign SHALL be 0 in every cycle other than the completion cycle.

Reset
REQ-017 rst SHALL force the state to IDLE and clear all outputs to 0 except req_ready=1 (dmem_req_valid=0, dmem_wmask=0, resp_valid=0); latched request registers SHALL clear to 0.
REQ-018 Reset asserted in REQ or WAIT SHALL abandon the access with no resp_valid; a memory response arriving after reset SHALL be ignored per REQ-015.

Structure
REQ-019 The following SHALL be added to CorePack: a mask_t (8-bit) typedef and a dmem_state_enum {IDLE,REQ,WAIT,ERR}.
REQ-020 Load shift/extension SHALL live in one combinational sub-module, dmem_load_ext (mem_op, addr[2:0], rdata -> data).

Verification
REQ-021 SB, addr 0x1003, req_wdata 0x00000000AB000000, ready=1 -> dmem_wmask 8'h08, dmem_wen 1, resp_valid on cycle 3, resp_rdata 0.
REQ-022 LH, addr 0x2006, dmem_rdata 0x8001_xxxx_xxxx_xxxx -> resp_rdata 0xFFFFFFFFFFFF8001; LHU same beat -> 0x0000000000008001.
REQ-023 LW, addr 0x2002 -> ERR: resp_valid=resp_misalign=1 next cycle, dmem_req_valid never asserted.
REQ-024 SD with dmem_req_ready held 0 for 5 cycles -> dmem_req_valid, addr, wdata, wmask 8'hFF stable all 5 cycles; req_ready 0 throughout.
REQ-025 Assert rst during WAIT, then pulse dmem_resp_valid -> no resp_valid, state IDLE, req_ready 1.
REQ-026 Two back-to-back LD requests -> second accepted the cycle after the first resp_valid, each returning its own beat unmodified.
